// File: rtl/multi_channel_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : multi_channel_accumulator
//  Purpose  : N-channel accumulator fed by a channel-tagged valid/ready stream.
//             Wrap or saturate, signed or unsigned, with sticky overflow flags.
//             A dump FSM streams every channel total out, optionally clearing
//             each channel as its beat is taken.
//  Revision : 1.0  initial release
// ============================================================================
module multi_channel_accumulator #(
    parameter  int DATA_W   = 16,
    parameter  int ACC_W    = 24,
    parameter  int NUM_CH   = 4,
    parameter  int SATURATE = 1,
    parameter  int SIGNED   = 0,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic              dump_start,
    input  logic              dump_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              out_last,
    output logic              busy,
    output logic [NUM_CH-1:0] ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    localparam logic [CH_W:0]    c_NUM_CH  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0]  c_LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [ACC_W-1:0] c_UMAX    = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] c_SMAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_SMIN    = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc [NUM_CH];
    logic [NUM_CH-1:0]  r_ovf;
    logic               r_dclr;
    logic               r_out_valid;
    logic [CH_W-1:0]    r_out_ch;
    logic [ACC_W-1:0]   r_out_data;
    logic               r_out_ovf;
    logic               r_out_last;

    logic               w_in_hs;
    logic               w_in_ok;
    logic               w_beat_hs;
    logic               w_load;
    logic               w_fwd;
    logic [CH_W-1:0]    w_in_idx;
    logic [CH_W-1:0]    w_ld_ch;
    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_cur;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_sat;
    logic [ACC_W-1:0]   w_new;
    logic [ACC_W-1:0]   w_ld_val;
    logic               w_ovf_s;
    logic               w_ovf_det;
    logic               w_ld_ovf;

    // Samples are refused while dumping, while clearing and while in reset.
    assign in_ready  = !reset && (r_state == ST_IDLE) && !clear;
    assign w_in_hs   = in_valid && in_ready;
    assign w_in_ok   = ({1'b0, in_ch} < c_NUM_CH);
    assign w_in_idx  = w_in_ok ? in_ch : '0;
    assign w_beat_hs = r_out_valid && out_ready;

    // Widen the sample to accumulator width (sign- or zero-extended).
    if (ACC_W > DATA_W) begin : g_ext_wide
        assign w_ext = (SIGNED != 0) ? {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data}
                                     : {{(ACC_W-DATA_W){1'b0}}, in_data};
    end else begin : g_ext_same
        assign w_ext = in_data;
    end

    // Sum in ACC_W+1 bits; overflow is carry-out (unsigned) or sign flip (signed).
    assign w_cur     = r_acc[w_in_idx];
    assign w_sum     = {1'b0, w_cur} + {1'b0, w_ext};
    assign w_ovf_s   = (w_cur[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != w_cur[ACC_W-1]);
    assign w_ovf_det = (SIGNED != 0) ? w_ovf_s : w_sum[ACC_W];
    assign w_sat     = (SIGNED != 0) ? (w_ext[ACC_W-1] ? c_SMIN : c_SMAX) : c_UMAX;
    assign w_new     = (w_ovf_det && (SATURATE != 0)) ? w_sat : w_sum[ACC_W-1:0];

    // A sample landing on the same edge as the first dump load is forwarded
    // so the dump includes it.
    assign w_fwd    = w_in_hs && w_in_ok && (w_in_idx == w_ld_ch);
    assign w_ld_val = w_fwd ? w_new : r_acc[w_ld_ch];
    assign w_ld_ovf = w_fwd ? (r_ovf[w_ld_ch] | w_ovf_det) : r_ovf[w_ld_ch];

    // Next-state logic and beat-load control; clear forces IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ld_ch     = '0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dump_start) begin
                        w_state_nxt = ST_DUMP;
                        w_load      = 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (w_beat_hs) begin
                        if (r_out_last) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_load  = 1'b1;
                            w_ld_ch = r_out_ch + CH_W'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-channel accumulators and sticky overflow flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
            r_ovf <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
            r_ovf <= '0;
        end else begin
            if (w_in_hs && w_in_ok) begin
                r_acc[w_in_idx] <= w_new;
                if (w_ovf_det) r_ovf[w_in_idx] <= 1'b1;
            end
            if (w_beat_hs && r_dclr) begin
                r_acc[r_out_ch] <= '0;
                r_ovf[r_out_ch] <= 1'b0;
            end
        end
    end

    // Registered dump beat: loaded on dump entry and after each non-last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_last  <= 1'b0;
            r_dclr      <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_last  <= 1'b0;
            r_dclr      <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= w_ld_ch;
            r_out_data  <= w_ld_val;
            r_out_ovf   <= w_ld_ovf;
            r_out_last  <= (w_ld_ch == c_LAST_CH);
            if (r_state == ST_IDLE) r_dclr <= dump_clear;
        end else if (w_beat_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_last  = r_out_last;
    assign busy      = (r_state == ST_DUMP);
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_channel_accumulator
//  Purpose  : Directed bench for multi_channel_accumulator with four
//             configurations sharing one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_channel_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_ch = '0;
    logic [15:0] in_data = '0;
    logic        clear = 1'b0;
    logic        dump_start = 1'b0;
    logic        dump_clear = 1'b0;
    logic        out_ready = 1'b0;

    logic        dut_in_ready, dut_out_valid, dut_out_ovf, dut_out_last, dut_busy;
    logic [1:0]  dut_out_ch;
    logic [23:0] dut_out_data;
    logic [3:0]  dut_ovf;

    logic        wrp_in_ready, wrp_out_valid, wrp_out_ovf, wrp_out_last, wrp_busy;
    logic [1:0]  wrp_out_ch;
    logic [23:0] wrp_out_data;
    logic [3:0]  wrp_ovf;

    logic        sgn_in_ready, sgn_out_valid, sgn_out_ovf, sgn_out_last, sgn_busy;
    logic [1:0]  sgn_out_ch;
    logic [15:0] sgn_out_data;
    logic [3:0]  sgn_ovf;

    logic        odd_in_ready, odd_out_valid, odd_out_ovf, odd_out_last, odd_busy;
    logic [1:0]  odd_out_ch;
    logic [23:0] odd_out_data;
    logic [2:0]  odd_ovf;

    logic [23:0] d_dut [4];
    logic [23:0] d_wrp [4];
    logic [23:0] d_sgn [4];
    logic [23:0] d_odd [4];
    logic        o_dut [4];
    logic        o_wrp [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_channel_accumulator #(.DATA_W(16), .ACC_W(24), .NUM_CH(4), .SATURATE(1), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(dut_in_ready), .in_ch(in_ch),
        .in_data(in_data), .clear(clear), .dump_start(dump_start), .dump_clear(dump_clear),
        .out_valid(dut_out_valid), .out_ready(out_ready), .out_ch(dut_out_ch), .out_data(dut_out_data),
        .out_ovf(dut_out_ovf), .out_last(dut_out_last), .busy(dut_busy), .ovf(dut_ovf));

    multi_channel_accumulator #(.DATA_W(16), .ACC_W(24), .NUM_CH(4), .SATURATE(0), .SIGNED(0)) u_wrp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(wrp_in_ready), .in_ch(in_ch),
        .in_data(in_data), .clear(clear), .dump_start(dump_start), .dump_clear(dump_clear),
        .out_valid(wrp_out_valid), .out_ready(out_ready), .out_ch(wrp_out_ch), .out_data(wrp_out_data),
        .out_ovf(wrp_out_ovf), .out_last(wrp_out_last), .busy(wrp_busy), .ovf(wrp_ovf));

    multi_channel_accumulator #(.DATA_W(16), .ACC_W(16), .NUM_CH(4), .SATURATE(1), .SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sgn_in_ready), .in_ch(in_ch),
        .in_data(in_data), .clear(clear), .dump_start(dump_start), .dump_clear(dump_clear),
        .out_valid(sgn_out_valid), .out_ready(out_ready), .out_ch(sgn_out_ch), .out_data(sgn_out_data),
        .out_ovf(sgn_out_ovf), .out_last(sgn_out_last), .busy(sgn_busy), .ovf(sgn_ovf));

    multi_channel_accumulator #(.DATA_W(16), .ACC_W(24), .NUM_CH(3), .SATURATE(1), .SIGNED(0)) u_odd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(odd_in_ready), .in_ch(in_ch),
        .in_data(in_data), .clear(clear), .dump_start(dump_start), .dump_clear(dump_clear),
        .out_valid(odd_out_valid), .out_ready(out_ready), .out_ch(odd_out_ch), .out_data(odd_out_data),
        .out_ovf(odd_out_ovf), .out_last(odd_out_last), .busy(odd_busy), .ovf(odd_ovf));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] d);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Run a full dump with out_ready high and capture every instance's beats.
    task automatic dump(input logic dclr);
        int cyc;
        for (int i = 0; i < 4; i++) begin
            d_dut[i] = 24'hBADBAD; d_wrp[i] = 24'hBADBAD;
            d_sgn[i] = 24'hBADBAD; d_odd[i] = 24'hBADBAD;
            o_dut[i] = 1'b0;       o_wrp[i] = 1'b0;
        end
        dump_start = 1'b1;
        dump_clear = dclr;
        tick();
        dump_start = 1'b0;
        dump_clear = 1'b0;
        out_ready  = 1'b1;
        cyc = 0;
        while ((dut_out_valid || wrp_out_valid || sgn_out_valid || odd_out_valid) && cyc < 20) begin
            if (dut_out_valid) begin d_dut[dut_out_ch] = dut_out_data; o_dut[dut_out_ch] = dut_out_ovf; end
            if (wrp_out_valid) begin d_wrp[wrp_out_ch] = wrp_out_data; o_wrp[wrp_out_ch] = wrp_out_ovf; end
            if (sgn_out_valid) d_sgn[sgn_out_ch] = {8'h00, sgn_out_data};
            if (odd_out_valid) d_odd[odd_out_ch] = odd_out_data;
            tick();
            cyc++;
        end
        chk("dump_ended", 32'(cyc < 20), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_in_ready", dut_in_ready, 0);
        chk("rst_out_valid", dut_out_valid, 0);
        chk("rst_busy", dut_busy, 0);
        chk("rst_ovf", dut_ovf, 0);
        chk("rst_out_data", dut_out_data, 0);
        repeat (2) tick();
        reset = 1'b0;

        // Unsigned saturate / wrap, signed sees the same words as -1
        for (int k = 0; k < 256; k++) send(2'd1, 16'hFFFF);
        chk("t1_ovf_pre", dut_ovf, 4'b0000);
        send(2'd1, 16'h0100);
        chk("t1_ovf_sat", dut_ovf, 4'b0010);
        chk("t1_ovf_wrap", wrp_ovf, 4'b0010);
        chk("t1_ovf_sgn", sgn_ovf, 4'b0000);
        dump(1'b0);
        chk("t1_acc_sat", d_dut[1], 24'hFFFFFF);
        chk("t1_beat_ovf_sat", o_dut[1], 1);
        chk("t1_acc_wrap", d_wrp[1], 24'h000000);
        chk("t1_beat_ovf_wrap", o_wrp[1], 1);
        chk("t1_acc_sgn", d_sgn[1], 24'h0000);
        chk("t1_acc_ch0", d_dut[0], 0);
        chk("t1_ovf_sticky", dut_ovf, 4'b0010);
        pulse_clear();
        chk("t1_ovf_clr", dut_ovf, 4'b0000);

        // Signed saturation both directions
        send(2'd0, 16'h7FFF);
        send(2'd0, 16'h0001);
        send(2'd2, 16'h8000);
        send(2'd2, 16'hFFFF);
        chk("t3_ovf_sgn", sgn_ovf, 4'b0101);
        chk("t3_ovf_uns", dut_ovf, 4'b0000);
        dump(1'b0);
        chk("t3_sgn_ch0", d_sgn[0], 24'h7FFF);
        chk("t3_sgn_ch2", d_sgn[2], 24'h8000);
        chk("t3_uns_ch0", d_dut[0], 24'h008000);
        chk("t3_uns_ch2", d_dut[2], 24'h017FFF);
        pulse_clear();

        // Stalled dump with clear-on-read
        send(2'd0, 16'd5);
        send(2'd1, 16'd6);
        send(2'd2, 16'd7);
        send(2'd3, 16'd8);
        dump_start = 1'b1;
        dump_clear = 1'b1;
        out_ready  = 1'b0;
        tick();
        dump_start = 1'b0;
        dump_clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_stall_valid", dut_out_valid, 1);
            chk("t4_stall_ch", dut_out_ch, 0);
            chk("t4_stall_data", dut_out_data, 5);
            chk("t4_in_ready", dut_in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("t4_beat_ch", dut_out_ch, b);
            chk("t4_beat_data", dut_out_data, 5 + b);
            chk("t4_beat_last", dut_out_last, 32'(b == 3));
            chk("t4_beat_busy", dut_busy, 1);
            tick();
        end
        out_ready = 1'b0;
        chk("t4_done_valid", dut_out_valid, 0);
        chk("t4_done_busy", dut_busy, 0);
        chk("t4_done_in_ready", dut_in_ready, 1);
        dump(1'b0);
        for (int i = 0; i < 4; i++) chk("t4_cleared", d_dut[i], 0);

        // Clear in the middle of a dump, and clear blocking a sample in IDLE
        send(2'd0, 16'd1);
        send(2'd1, 16'd2);
        send(2'd2, 16'd3);
        send(2'd3, 16'h7FFF);
        send(2'd3, 16'h7FFF);
        chk("t5_sgn_ovf", sgn_ovf, 4'b1000);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("t5_at_ch2", dut_out_ch, 2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_ch    = 2'd0;
        in_data  = 16'd9;
        out_ready = 1'b0;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t5_clr_valid", dut_out_valid, 0);
        chk("t5_clr_busy", dut_busy, 0);
        chk("t5_clr_ovf", sgn_ovf, 0);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_ch      = 2'd1;
        in_data    = 16'd5;
        dump_start = 1'b1;
        #1;
        chk("t5_clr_in_ready", dut_in_ready, 0);
        tick();
        clear      = 1'b0;
        in_valid   = 1'b0;
        dump_start = 1'b0;
        chk("t5_clr_no_dump", dut_busy, 0);
        dump(1'b0);
        for (int i = 0; i < 4; i++) chk("t5_acc_zero", d_dut[i], 0);

        // Asynchronous reset mid-dump, then an out-of-range channel
        send(2'd0, 16'h0010);
        send(2'd1, 16'h8000);
        send(2'd1, 16'h8000);
        chk("t6_sgn_ovf_pre", sgn_ovf, 4'b0010);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("t6_pre_valid", dut_out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", dut_out_valid, 0);
        chk("t6_rst_busy", dut_busy, 0);
        chk("t6_rst_data", dut_out_data, 0);
        chk("t6_rst_ovf", sgn_ovf, 0);
        chk("t6_rst_in_ready", dut_in_ready, 0);
        tick();
        reset = 1'b0;
        send(2'd0, 16'd1);
        chk("t6_odd_in_ready", odd_in_ready, 1);
        send(2'd3, 16'h1234);
        dump(1'b0);
        chk("t6_odd_ch0", d_odd[0], 1);
        chk("t6_odd_ch1", d_odd[1], 0);
        chk("t6_odd_ch2", d_odd[2], 0);
        chk("t6_dut_ch0", d_dut[0], 1);
        chk("t6_dut_ch3", d_dut[3], 24'h001234);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
